// File: rtl/sim_run_pkg.sv
// Shared types and helpers for the bring-up run controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package sim_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        RST,
        RUN,
        DONE
    } run_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Integer clocks per UART bit; callers must keep the result >= 4 so the
    // half-bit start re-check lands at least one cycle after the edge.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver watching the core's TX line, with glitch and framing checks.
// Latency: strobe one cycle after the stop-bit sample (2-flop sync ahead of the decoder).
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module uart_rx_monitor
    import sim_run_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    byte_nx;
    logic          valid_nx, ferr_nx;
    logic          sync_q1, sync_q2;

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= rx;
            sync_q2 <= sync_q1;
        end
    end

    // Decoder state, baud counter, shift register and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift     <= shift_nx;
            rx_valid  <= valid_nx;
            rx_byte   <= byte_nx;
            frame_err <= ferr_nx;
        end
    end

    // Next-state decode: start edge, mid-bit re-check, 8 data samples, stop check.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        byte_nx    = rx_byte;
        valid_nx   = 1'b0;
        ferr_nx    = 1'b0;
        if (!en) begin
            // Disabled: drop anything in flight and wait for a fresh start edge.
            state_nx = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (sync_q2 && !sync_q1) begin
                        state_nx = RX_START;
                        cnt_nx   = HALF_M1;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (!sync_q2) begin
                            state_nx   = RX_DATA;
                            cnt_nx     = FULL_M1;
                            bit_idx_nx = 3'd0;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a frame.
                            state_nx = RX_IDLE;
                        end
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shift_nx   = {sync_q2, shift[7:1]};
                        cnt_nx     = FULL_M1;
                        bit_idx_nx = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_nx = RX_STOP;
                        end
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        if (sync_q2) begin
                            valid_nx = 1'b1;
                            byte_nx  = shift;
                            state_nx = RX_IDLE;
                        end else begin
                            ferr_nx  = 1'b1;
                            state_nx = RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A low stop bit may be a break; resync only once the line idles.
                    if (sync_q2) begin
                        state_nx = RX_IDLE;
                    end
                end
                default: state_nx = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: sequences core reset, bounds the run, ends it on UART pass/fail bytes.
// Latency: run ends the cycle after a matching byte strobe or on the TIMEOUT_CYCLES-th RUN cycle.
// Backpressure: none; i_start is level-sampled and ignored outside IDLE/DONE.
module sim_run_controller
    import sim_run_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned BAUD             = 115_200,
    parameter int unsigned PRE_RESET_CYCLES = 3,
    parameter int unsigned RESET_CYCLES     = 5,
    parameter int unsigned TIMEOUT_CYCLES   = 250,
    parameter logic [7:0]  PASS_BYTE        = 8'h50,
    parameter logic [7:0]  FAIL_BYTE        = 8'h46
) (
    input  logic        i_clk_50mhz,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_rx,
    output logic        o_dut_reset_n,
    output logic        o_running,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic        o_rx_valid,
    output logic [7:0]  o_rx_byte,
    output logic        o_frame_err,
    output logic [31:0] o_cycle_count
);

    localparam int          CPB      = clks_per_bit(int'(CLK_HZ), int'(BAUD));
    localparam logic [31:0] PRE_LOAD = 32'(PRE_RESET_CYCLES - 1);
    localparam logic [31:0] RST_LOAD = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] TMO_L    = 32'(TIMEOUT_CYCLES);

    run_state_t  state, state_nx;
    logic [31:0] phase, phase_nx;
    logic [31:0] count, count_nx, count_inc;
    logic        done_q, done_nx;
    logic        pass_q, pass_nx;
    logic        tmo_q, tmo_nx;
    logic        launch;
    logic        rx_en;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        pass_hit, fail_hit, tmo_hit;

    assign rx_en = (state == RUN) || (state == DONE);

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB)
    ) u_rx (
        .clk       (i_clk_50mhz),
        .rst_n     (i_reset_n),
        .en        (rx_en),
        .rx        (i_rx),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (o_frame_err)
    );

    assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    assign pass_hit  = rx_valid && (rx_byte == PASS_BYTE);
    assign fail_hit  = rx_valid && (rx_byte == FAIL_BYTE);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (count_inc == TMO_L);

    // Run FSM state, phase counter, cycle counter and result flags.
    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            phase  <= '0;
            count  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            count  <= count_nx;
            done_q <= done_nx;
            pass_q <= pass_nx;
            tmo_q  <= tmo_nx;
        end
    end

    // Next-state logic: reset sequencing, run bounding, and pass/fail/timeout resolution.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        count_nx = count;
        done_nx  = done_q;
        pass_nx  = pass_q;
        tmo_nx   = tmo_q;
        launch   = 1'b0;
        case (state)
            IDLE: launch = i_start;
            PRE: begin
                if (phase == '0) begin
                    if (RESET_CYCLES != 0) begin
                        state_nx = RST;
                        phase_nx = RST_LOAD;
                    end else begin
                        state_nx = RUN;
                        count_nx = '0;
                    end
                end else begin
                    phase_nx = phase - 32'd1;
                end
            end
            RST: begin
                if (phase == '0) begin
                    state_nx = RUN;
                    count_nx = '0;
                end else begin
                    phase_nx = phase - 32'd1;
                end
            end
            RUN: begin
                count_nx = count_inc;
                // A byte arriving on the timeout cycle wins over the timeout.
                if (pass_hit) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b1;
                    tmo_nx   = 1'b0;
                end else if (fail_hit) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b0;
                    tmo_nx   = 1'b0;
                end else if (tmo_hit) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b0;
                    tmo_nx   = 1'b1;
                end
            end
            DONE: launch = i_start;
            default: state_nx = IDLE;
        endcase
        // Zero-length PRE/RST phases are skipped without spending a cycle in them.
        if (launch) begin
            done_nx = 1'b0;
            pass_nx = 1'b0;
            tmo_nx  = 1'b0;
            if (PRE_RESET_CYCLES != 0) begin
                state_nx = PRE;
                phase_nx = PRE_LOAD;
            end else if (RESET_CYCLES != 0) begin
                state_nx = RST;
                phase_nx = RST_LOAD;
            end else begin
                state_nx = RUN;
                count_nx = '0;
            end
        end
    end

    assign o_dut_reset_n = (state != RST);
    assign o_running     = (state == RUN);
    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_timeout     = tmo_q;
    assign o_rx_valid    = rx_valid;
    assign o_rx_byte     = rx_byte;
    assign o_cycle_count = count;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed plus randomized bench for sim_run_controller with a run-outcome reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sim_run_controller;

    localparam int          TMO    = 400;
    localparam logic [7:0]  P_BYTE = 8'h50;
    localparam logic [7:0]  F_BYTE = 8'h46;
    // RUN-cycle index (1-based) in which a byte's strobe appears, relative to the
    // tick (counted from the start edge) at which its start bit is driven:
    // 8 cycles of PRE+RST precede RUN; sync, half-bit re-check and nine more
    // 10-cycle bit periods bring the stop sample 97 edges after launch.
    localparam int          STROBE_LAT = 90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rx;
    logic        dut_reset_n, running, done, pass, timeout;
    logic        rx_valid, frame_err;
    logic [7:0]  rx_byte;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    sim_run_controller #(
        .CLK_HZ           (1_000_000),
        .BAUD             (100_000),
        .PRE_RESET_CYCLES (3),
        .RESET_CYCLES     (5),
        .TIMEOUT_CYCLES   (TMO),
        .PASS_BYTE        (P_BYTE),
        .FAIL_BYTE        (F_BYTE)
    ) dut (
        .i_clk_50mhz   (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_rx          (rx),
        .o_dut_reset_n (dut_reset_n),
        .o_running     (running),
        .o_done        (done),
        .o_pass        (pass),
        .o_timeout     (timeout),
        .o_rx_valid    (rx_valid),
        .o_rx_byte     (rx_byte),
        .o_frame_err   (frame_err),
        .o_cycle_count (cycle_count)
    );

    typedef struct {
        int         d;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] got_q[$];
    int         ferr_seen = 0;
    int         total = 0;
    int         bad = 0;
    int         rt = 0;
    int         base_v = 0;
    int         base_f = 0;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)  got_q.push_back(rx_byte);
        if (frame_err) ferr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        evq.push_back('{d: rt, b: b, ok: stop_bit});
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = stop_bit;
        tick(10);
        rx = 1'b1;
    endtask

    task automatic begin_run();
        evq.delete();
        base_v = got_q.size();
        base_f = ferr_seen;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rt = 0;
    endtask

    // Reference outcome: earliest good pass/fail byte whose strobe falls within
    // the timeout window decides; otherwise the run times out after TMO cycles.
    task automatic finish_run(input string tag);
        bit         e_pass, e_tmo, found;
        int         e_cnt, w, n_good, n_bad, idx;
        logic [7:0] good_q[$];
        e_pass = 0; e_tmo = 1; e_cnt = TMO; found = 0; n_bad = 0;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].ok) good_q.push_back(evq[i].b);
            else           n_bad++;
            if (!found && evq[i].ok && (evq[i].b == P_BYTE || evq[i].b == F_BYTE)
                && evq[i].d + STROBE_LAT <= TMO) begin
                found  = 1;
                e_pass = (evq[i].b == P_BYTE);
                e_tmo  = 0;
                e_cnt  = evq[i].d + STROBE_LAT;
            end
        end
        w = 0;
        while (!done && w < 700) begin
            tick(1);
            w++;
        end
        chk({tag, "_done"},    32'(done),        32'd1);
        chk({tag, "_pass"},    32'(pass),        32'(e_pass));
        chk({tag, "_timeout"}, 32'(timeout),     32'(e_tmo));
        chk({tag, "_count"},   cycle_count,      32'(e_cnt));
        chk({tag, "_running"}, 32'(running),     32'd0);
        chk({tag, "_ferr"},    32'(ferr_seen - base_f), 32'(n_bad));
        n_good = got_q.size() - base_v;
        chk({tag, "_nstrobe"}, 32'(n_good),      32'(good_q.size()));
        if (n_good == good_q.size()) begin
            for (int i = 0; i < n_good; i++) begin
                idx = base_v + i;
                chk({tag, "_byte"}, 32'(got_q[idx]), 32'(good_q[i]));
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        int         nb;
        rst_n = 1'b0;
        start = 1'b0;
        rx    = 1'b1;
        tick(3);
        chk("rst_dut_reset_n", 32'(dut_reset_n), 32'd1);
        chk("rst_running",     32'(running),     32'd0);
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_pass",        32'(pass),        32'd0);
        chk("rst_timeout",     32'(timeout),     32'd0);
        chk("rst_rx_valid",    32'(rx_valid),    32'd0);
        chk("rst_rx_byte",     32'(rx_byte),     32'd0);
        chk("rst_frame_err",   32'(frame_err),   32'd0);
        chk("rst_count",       cycle_count,      32'd0);
        rst_n = 1'b1;
        tick(2);

        // Reset sequencing: released 3 cycles, low 5 cycles, then RUN.
        begin_run();
        for (int t = 0; t < 10; t++) begin
            chk("seq_dut_reset_n", 32'(dut_reset_n), (t >= 3 && t <= 7) ? 32'd0 : 32'd1);
            chk("seq_running",     32'(running),     (t >= 8) ? 32'd1 : 32'd0);
            tick(1);
        end
        send_byte(P_BYTE, 1'b1);
        finish_run("pass50");

        // Restart from DONE, then an ordinary byte followed by the fail byte.
        begin_run();
        chk("rerun_done_clr", 32'(done), 32'd0);
        chk("rerun_pass_clr", 32'(pass), 32'd0);
        tick(12);
        send_byte(8'h41, 1'b1);
        tick(5);
        send_byte(F_BYTE, 1'b1);
        finish_run("fail46");

        // Silent line runs to the timeout; a start pulse in RUN is ignored.
        begin_run();
        tick(50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk("ign_running",     32'(running),     32'd1);
            chk("ign_dut_reset_n", 32'(dut_reset_n), 32'd1);
            tick(1);
        end
        finish_run("silent");

        // Pass byte whose strobe lands on the last RUN cycle, then one cycle late.
        begin_run();
        tick(310);
        send_byte(P_BYTE, 1'b1);
        finish_run("edge400");
        begin_run();
        tick(311);
        send_byte(P_BYTE, 1'b1);
        finish_run("edge401");

        // Framing error and a short glitch: no good strobe, run keeps going.
        begin_run();
        tick(20);
        send_byte(P_BYTE, 1'b0);
        chk("ferr_running", 32'(running), 32'd1);
        chk("ferr_done",    32'(done),    32'd0);
        tick(10);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        chk("glitch_nstrobe", 32'(got_q.size() - base_v), 32'd0);
        finish_run("ferr");

        // Asynchronous reset in the middle of a byte.
        begin_run();
        tick(20);
        rx = 1'b0;
        tick(35);
        rst_n = 1'b0;
        #1;
        chk("arst_dut_reset_n", 32'(dut_reset_n), 32'd1);
        chk("arst_running",     32'(running),     32'd0);
        chk("arst_done",        32'(done),        32'd0);
        chk("arst_count",       cycle_count,      32'd0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        begin_run();
        tick(15);
        send_byte(P_BYTE, 1'b1);
        finish_run("after_arst");

        // Randomized runs against the outcome model.
        for (int r = 0; r < 6; r++) begin
            begin_run();
            tick($urandom_range(0, 60));
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                case ($urandom_range(0, 3))
                    0:       v = P_BYTE;
                    1:       v = F_BYTE;
                    default: begin
                        v = 8'($urandom_range(0, 255));
                        while (v == P_BYTE || v == F_BYTE) v = 8'($urandom_range(0, 255));
                    end
                endcase
                send_byte(v, ($urandom_range(0, 3) != 0));
                tick($urandom_range(4, 40));
            end
            finish_run("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
